// File: rtl/iwdg_window.sv
// Independent watchdog with key-protected prescaler/reload/window registers.
// Drives a fixed-length active-low reset pulse on timeout or early refresh.
module iwdg_window #(
   parameter int CNT_W     = 12,
   parameter int RST_PULSE = 4
) (
   input  logic             CLOCK,
   input  logic             aCore_signal,
   input  logic             i_kr_wr,
   input  logic [15:0]      i_kr,
   input  logic             i_pr_wr,
   input  logic [2:0]       i_pr,
   input  logic             i_rlr_wr,
   input  logic [CNT_W-1:0] i_rlr,
   input  logic             i_winr_wr,
   input  logic [CNT_W-1:0] i_winr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_running,
   output logic             o_unlocked,
   output logic             o_rst_n,
   output logic             o_wdg_flag
);

   // state   | meaning
   // S_IDLE  | not started, counter frozen
   // S_RUN   | prescaler and down-counter active, refresh accepted
   // S_FAULT | reset pulse being driven, all writes ignored
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2} state_t;

   localparam int               PW          = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
   localparam logic [PW-1:0]    PULSE_LAST  = PW'(RST_PULSE - 1);
   localparam logic [CNT_W-1:0] ALL1        = '1;
   localparam logic [15:0]      KEY_START   = 16'hCCCC;
   localparam logic [15:0]      KEY_REFRESH = 16'hAAAA;
   localparam logic [15:0]      KEY_UNLOCK  = 16'h5555;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       psc_q, psc_d;
   logic [2:0]       pr_q, pr_d;
   logic [CNT_W-1:0] rlr_q, rlr_d;
   logic [CNT_W-1:0] winr_q, winr_d;
   logic             unl_q, unl_d;
   logic             run_q, run_d;
   logic             rst_n_q, rst_n_d;
   logic             flag_q, flag_d;
   logic [PW-1:0]    pulse_q, pulse_d;

   logic       key_start, key_refresh, cfg_ok, tick, fault;
   logic [2:0] pr_eff;
   logic [7:0] psc_tc;

   assign key_start   = i_kr_wr && (i_kr == KEY_START);
   assign key_refresh = i_kr_wr && (i_kr == KEY_REFRESH);
   assign cfg_ok      = unl_q && (state_q != S_FAULT);
   // code 7 saturates at /256; terminal count is (4<<p)-1
   assign pr_eff      = (pr_q == 3'd7) ? 3'd6 : pr_q;
   assign psc_tc      = 8'hFF >> (3'd6 - pr_eff);
   assign tick        = (state_q == S_RUN) && (psc_q == psc_tc);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      psc_d   = psc_q;
      pr_d    = pr_q;
      rlr_d   = rlr_q;
      winr_d  = winr_q;
      unl_d   = unl_q;
      run_d   = run_q;
      rst_n_d = rst_n_q;
      flag_d  = flag_q;
      pulse_d = pulse_q;
      fault   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (key_start) begin
               state_d = S_RUN;
               run_d   = 1'b1;
               cnt_d   = rlr_q;
               psc_d   = '0;
            end
         end
         S_RUN: begin
            psc_d = tick ? 8'd0 : psc_q + 8'd1;
            if (key_refresh) begin
               if (cnt_q > winr_q) begin
                  fault = 1'b1;
               end else begin
                  cnt_d = rlr_q;
                  psc_d = '0;
               end
            end else if (tick) begin
               if (cnt_q == '0) fault = 1'b1;
               else             cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_FAULT: begin
            if (pulse_q == '0) begin
               state_d = S_RUN;
               rst_n_d = 1'b1;
               cnt_d   = rlr_q;
               psc_d   = '0;
            end else begin
               pulse_d = pulse_q - PW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fault) begin
         state_d = S_FAULT;
         rst_n_d = 1'b0;
         flag_d  = 1'b1;
         pulse_d = PULSE_LAST;
      end

      // start/refresh keys leave the lock state alone
      if (i_kr_wr && (state_q != S_FAULT)) begin
         if (i_kr == KEY_UNLOCK)                              unl_d = 1'b1;
         else if ((i_kr != KEY_START) && (i_kr != KEY_REFRESH)) unl_d = 1'b0;
      end

      if (cfg_ok) begin
         if (i_pr_wr) begin
            pr_d  = i_pr;
            psc_d = '0;
         end
         if (i_rlr_wr)  rlr_d  = i_rlr;
         if (i_winr_wr) winr_d = i_winr;
      end
   end

   always_ff @(posedge CLOCK or negedge aCore_signal) begin
      if (!aCore_signal) begin
         state_q <= S_IDLE;
         cnt_q   <= ALL1;
         psc_q   <= '0;
         pr_q    <= '0;
         rlr_q   <= ALL1;
         winr_q  <= ALL1;
         unl_q   <= 1'b0;
         run_q   <= 1'b0;
         rst_n_q <= 1'b1;
         flag_q  <= 1'b0;
         pulse_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         psc_q   <= psc_d;
         pr_q    <= pr_d;
         rlr_q   <= rlr_d;
         winr_q  <= winr_d;
         unl_q   <= unl_d;
         run_q   <= run_d;
         rst_n_q <= rst_n_d;
         flag_q  <= flag_d;
         pulse_q <= pulse_d;
      end
   end

   assign o_cnt      = cnt_q;
   assign o_running  = run_q;
   assign o_unlocked = unl_q;
   assign o_rst_n    = rst_n_q;
   assign o_wdg_flag = flag_q;

endmodule

// File: tb/tb_iwdg_window.sv
// Bench for iwdg_window: per-cycle expectations from a timestamp-based model,
// checked by a monitor that pops one expectation after every rising edge.
module tb_iwdg_window;
   localparam int CNT_W     = 12;
   localparam int RST_PULSE = 4;
   localparam int ALL1      = (1 << CNT_W) - 1;
   localparam int ST_IDLE = 0, ST_RUN = 1, ST_FAULT = 2;

   logic             CLOCK = 1'b0;
   logic             aCore_signal = 1'b0;
   logic             i_kr_wr = 1'b0;
   logic [15:0]      i_kr = '0;
   logic             i_pr_wr = 1'b0;
   logic [2:0]       i_pr = '0;
   logic             i_rlr_wr = 1'b0;
   logic [CNT_W-1:0] i_rlr = '0;
   logic             i_winr_wr = 1'b0;
   logic [CNT_W-1:0] i_winr = '0;
   logic [CNT_W-1:0] o_cnt;
   logic             o_running, o_unlocked, o_rst_n, o_wdg_flag;

   iwdg_window #(.CNT_W(CNT_W), .RST_PULSE(RST_PULSE)) dut (
      .CLOCK(CLOCK), .aCore_signal(aCore_signal),
      .i_kr_wr(i_kr_wr), .i_kr(i_kr), .i_pr_wr(i_pr_wr), .i_pr(i_pr),
      .i_rlr_wr(i_rlr_wr), .i_rlr(i_rlr), .i_winr_wr(i_winr_wr), .i_winr(i_winr),
      .o_cnt(o_cnt), .o_running(o_running), .o_unlocked(o_unlocked),
      .o_rst_n(o_rst_n), .o_wdg_flag(o_wdg_flag)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             run;
      logic             unl;
      logic             rstn;
      logic             flag;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model: counter value = base - elapsed_edges/div since the last anchor
   // (start, reload or prescaler write); timeout is a computed edge number.
   int m_t, m_state, m_base, m_anchor, m_div, m_rlr, m_winr, m_frozen, m_fend, m_last_cnt;
   bit m_unl, m_flag;

   function automatic int cur(int tt);
      return m_base - (tt - m_anchor) / m_div;
   endfunction

   task automatic push_exp();
      exp_t e;
      m_last_cnt = (m_state == ST_RUN) ? cur(m_t) : m_frozen;
      e.cnt  = CNT_W'(m_last_cnt);
      e.run  = (m_state != ST_IDLE);
      e.unl  = m_unl;
      e.rstn = (m_state != ST_FAULT);
      e.flag = m_flag;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLOCK);
         aCore_signal = 1'b0;
         i_kr_wr = 0; i_pr_wr = 0; i_rlr_wr = 0; i_winr_wr = 0;
         m_t = 0; m_state = ST_IDLE; m_base = ALL1; m_anchor = 0; m_div = 4;
         m_rlr = ALL1; m_winr = ALL1; m_frozen = ALL1; m_fend = 0;
         m_unl = 0; m_flag = 0;
         push_exp();
      end
   endtask

   task automatic cyc(input bit kw, input logic [15:0] k, input bit pw, input logic [2:0] p,
                      input bit rw, input int r, input bit ww, input int w);
      int pre, cpre;
      bit unl, flt;
      @(negedge CLOCK);
      aCore_signal = 1'b1;
      i_kr_wr = kw; i_kr = k; i_pr_wr = pw; i_pr = p;
      i_rlr_wr = rw; i_rlr = CNT_W'(r); i_winr_wr = ww; i_winr = CNT_W'(w);

      m_t++;
      pre = m_state; unl = m_unl; flt = 0;
      if (pre == ST_FAULT) begin
         if (m_t == m_fend) begin m_state = ST_RUN; m_base = m_rlr; m_anchor = m_t; end
      end else if (pre == ST_RUN) begin
         cpre = cur(m_t - 1);
         if (kw && k == 16'hAAAA) begin
            if (cpre > m_winr) begin flt = 1; m_frozen = cpre; end
            else begin m_base = m_rlr; m_anchor = m_t; end
         end else if (m_t == m_anchor + (m_base + 1) * m_div) begin
            flt = 1; m_frozen = 0;
         end
      end else if (kw && k == 16'hCCCC) begin
         m_state = ST_RUN; m_base = m_rlr; m_anchor = m_t;
      end
      if (flt) begin m_state = ST_FAULT; m_fend = m_t + RST_PULSE; m_flag = 1; end
      if (pre != ST_FAULT) begin
         if (kw) begin
            if (k == 16'h5555) m_unl = 1;
            else if (k != 16'hCCCC && k != 16'hAAAA) m_unl = 0;
         end
         if (unl) begin
            if (pw) begin
               if (m_state == ST_RUN) begin m_base = cur(m_t); m_anchor = m_t; end
               m_div = 4 << ((p == 3'd7) ? 6 : int'(p));
            end
            if (rw) m_rlr = r;
            if (ww) m_winr = w;
         end
      end
      push_exp();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 3'd0, 0, 0, 0, 0);
   endtask
   task automatic key(input logic [15:0] k);  cyc(1, k, 0, 3'd0, 0, 0, 0, 0); endtask
   task automatic wr_pr(input logic [2:0] p); cyc(0, 16'h0, 1, p, 0, 0, 0, 0); endtask
   task automatic wr_rlr(int r);              cyc(0, 16'h0, 0, 3'd0, 1, r, 0, 0); endtask
   task automatic wr_winr(int w);             cyc(0, 16'h0, 0, 3'd0, 0, 0, 1, w); endtask

   task automatic wait_model(int want_state, int want_cnt);
      int i;
      for (i = 0; i < 3000; i++) begin
         if (m_state == want_state && (want_cnt < 0 || m_last_cnt == want_cnt)) break;
         idle(1);
      end
      if (i == 3000) begin
         n_tests++; n_fail++;
         $display("FAIL wait_bound: state %0d cnt %0d never reached", want_state, want_cnt);
      end
   endtask

   always @(posedge CLOCK) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (o_cnt !== e.cnt || o_running !== e.run || o_unlocked !== e.unl ||
             o_rst_n !== e.rstn || o_wdg_flag !== e.flag) begin
            n_fail++;
            $display("FAIL outputs @%0t: cnt=%0d exp %0d, running=%0b exp %0b, unlocked=%0b exp %0b, rst_n=%0b exp %0b, flag=%0b exp %0b",
                     $time, o_cnt, e.cnt, o_running, e.run, o_unlocked, e.unl,
                     o_rst_n, e.rstn, o_wdg_flag, e.flag);
         end
      end
   end

   task automatic check_now(string name, int act, int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   initial begin
      logic [15:0] k;
      int sel;

      do_reset(3);

      // timeout: pulse 16 edges after start, 4 cycles long, then reload to 3
      key(16'h5555); wr_pr(3'd0); wr_rlr(3); key(16'hCCCC); idle(30);

      // lock behaviour
      do_reset(2);
      wr_rlr(5); key(16'h5555); wr_rlr(5); key(16'h1234); wr_rlr(7);
      key(16'hCCCC); idle(40);

      // periodic refresh, then starve
      do_reset(2);
      key(16'h5555); wr_pr(3'd2); wr_rlr(10); key(16'hCCCC);
      for (int i = 0; i < 20; i++) begin idle(99); key(16'hAAAA); end
      idle(200);

      // window: early refresh at 80 faults, refresh at 40 reloads
      do_reset(2);
      key(16'h5555); wr_pr(3'd0); wr_rlr(100); wr_winr(50); key(16'hCCCC);
      wait_model(ST_RUN, 80); key(16'hAAAA);
      wait_model(ST_RUN, 40); key(16'hAAAA); idle(20);

      // refresh on the zero tick, then writes during FAULT
      do_reset(2);
      key(16'h5555); wr_rlr(1); key(16'hCCCC); idle(7); key(16'hAAAA); idle(8);
      key(16'h1234); wr_rlr(9); key(16'hAAAA); key(16'hCCCC);
      idle(6); wr_rlr(2); idle(20);

      // randomized traffic
      do_reset(2);
      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 3);
         k = (sel == 0) ? 16'hCCCC : (sel == 1) ? 16'hAAAA : (sel == 2) ? 16'h5555 : 16'($urandom);
         cyc($urandom_range(0, 15) == 0, k,
             $urandom_range(0, 39) == 0, 3'($urandom_range(0, 7)),
             $urandom_range(0, 39) == 0, $urandom_range(0, 47),
             $urandom_range(0, 39) == 0, ($urandom_range(0, 1) == 1) ? ALL1 : $urandom_range(0, 47));
      end

      // async reset in the second FAULT cycle
      do_reset(2);
      key(16'h5555); wr_rlr(3); key(16'hCCCC);
      wait_model(ST_FAULT, -1);
      idle(1);
      @(posedge CLOCK);
      #3;
      aCore_signal = 1'b0;
      #1;
      check_now("async_rst_n", int'(o_rst_n), 1);
      check_now("async_flag", int'(o_wdg_flag), 0);
      check_now("async_running", int'(o_running), 0);
      check_now("async_unlocked", int'(o_unlocked), 0);
      check_now("async_cnt", int'(o_cnt), ALL1);
      repeat (2) @(negedge CLOCK);
      check_now("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iwdg_window.md
# iwdg_window

Parametrised independent watchdog with key-protected configuration, programmable prescaler, reload value and refresh window. Once started by a key write it cannot be stopped except by `aCore_signal`. On timeout or on an early (out-of-window) refresh it drives a fixed-length active-low reset pulse to the core reset tree and sets a sticky cause flag. It sits beside the core reset logic and is fed by the bus register-write decode.

## Interface

**Parameters**
- `CNT_W`, default 12: down-counter, reload and window width.
- `RST_PULSE`, default 4: length of the reset pulse in `CLOCK` cycles. Must be ≥1.

**Ports**
- `CLOCK`, input, 1: single clock; all state changes on its rising edge.
- `aCore_signal`, input, 1: asynchronous, active-low reset.
- `i_kr_wr`, input, 1: key register write strobe.
- `i_kr`, input, 16: key value.
- `i_pr_wr`, input, 1: prescaler write strobe.
- `i_pr`, input, 3: prescaler code.
- `i_rlr_wr`, input, 1: reload register write strobe.
- `i_rlr`, input, CNT_W: reload value.
- `i_winr_wr`, input, 1: window register write strobe.
- `i_winr`, input, CNT_W: window value.
- `o_cnt`, output, CNT_W: current down-counter value.
- `o_running`, output, 1: watchdog started.
- `o_unlocked`, output, 1: PR/RLR/WINR write access open.
- `o_rst_n`, output, 1: active-low reset pulse to the core.
- `o_wdg_flag`, output, 1: sticky flag indicating that a watchdog reset has occurred.

## Operation

**Reset values**
- `o_cnt` = all ones; PR = 0; RLR = all ones; WINR = all ones.
- `o_running` = 0; `o_unlocked` = 0; `o_rst_n` = 1; `o_wdg_flag` = 0.
- State = IDLE; prescaler count = 0.

**Keys** (sampled when `i_kr_wr` = 1)
- 16'hCCCC: start. IDLE→RUN, counter←RLR, prescaler←0. No effect once already RUN.
- 16'hAAAA: refresh, valid in RUN only.
  - If counter > WINR: early refresh, go to FAULT.
  - Otherwise: counter←RLR, prescaler←0.
- 16'h5555: `o_unlocked`←1.
- Any other value: `o_unlocked`←0.

**Configuration writes**
- PR/RLR/WINR writes take effect only while `o_unlocked` = 1; otherwise they are silently dropped.
- PR code p gives a divide ratio of 4<<p. Code 7 is treated as 6, i.e. /256.
- A PR write clears the prescaler count.
- An RLR write does not change the counter; the new value is used at the next reload.
- WINR = all ones disables the window check.

**States**
- IDLE: counter frozen.
- RUN:
  - Prescaler counts 0..(4<<p)−1 and produces a tick at the terminal count.
  - On a tick: counter decrements if > 0; if counter = 0, go to FAULT (timeout).
- FAULT:
  - `o_rst_n` = 0 for exactly RST_PULSE cycles; `o_wdg_flag`←1.
  - Key and configuration writes are ignored.
  - Then return to RUN with counter←RLR and prescaler←0.
  - `o_running` stays 1 throughout.
- `o_wdg_flag` is cleared only by `aCore_signal`.

**Priorities (same cycle)**
- Refresh and tick together: refresh wins, no decrement.
- Early refresh and tick-at-zero together: single FAULT entry.
- Key and configuration write together: both are applied; the lock state is evaluated before the key write takes effect.
- `aCore_signal` asserted mid-FAULT: `o_rst_n` returns to 1 immediately and all state goes to reset values.

## Timing
- All outputs are registered. Effects of a write sampled at edge N are visible after edge N.
- Start at edge N, then no refresh: first tick at edge N+(4<<p). Timeout entry at edge N+(RLR+1)·(4<<p). `o_rst_n` is low from that edge through RST_PULSE edges.
- After a refresh at edge M, the next timeout entry is at edge M+(RLR+1)·(4<<p).
- Early refresh at edge M: `o_rst_n` goes low after edge M.
- `o_cnt` updates only on a tick, a reload, or reset.

## Test plan
- Timeout: PR=0, RLR=3, start → `o_rst_n` goes low exactly 16 cycles after the start edge, stays low 4 cycles, `o_wdg_flag`=1, `o_cnt` reloads to 3 and counting resumes.
- Lock: write RLR=5 without 5555 → RLR stays 0xFFF. Write 5555 then RLR=5 → accepted. Write key 1234 then RLR=7 → RLR stays 5.
- Refresh: PR=2 (/16), RLR=10, refresh every 100 cycles for 2000 cycles → no reset pulse. Stop refreshing → pulse 176 cycles after the last refresh.
- Window: RLR=100, WINR=50, refresh while `o_cnt`=80 → immediate FAULT. Refresh at `o_cnt`=40 → reload to 100, no pulse.
- Collision: refresh on a tick cycle with `o_cnt`=0 → reload, no FAULT. Key writes during FAULT → ignored.
- Async reset: assert `aCore_signal` in the 2nd FAULT cycle → `o_rst_n`=1, `o_wdg_flag`=0, `o_running`=0 immediately, without waiting for a clock edge.
